// File: rtl/conv2d_mac_if.sv
// conv2d_mac_if: window, coefficient-load and result bundle for conv2d_mac.
// master drives windows/coefficients; slave is the MAC datapath.
interface conv2d_mac_if #(
  parameter int K_KERNEL = 3,
  parameter int BWD      = 8,
  parameter int WBWD     = 8,
  parameter int ACC_W    = BWD + WBWD + $clog2(K_KERNEL*K_KERNEL) + 1
);
  logic [K_KERNEL*K_KERNEL*BWD-1:0] i_window;
  logic                             i_window_valid;
  logic                             i_window_end;
  logic signed [WBWD-1:0]           i_w_data;
  logic                             i_w_valid;
  logic                             o_w_loaded;
  logic signed [ACC_W-1:0]          o_result;
  logic                             o_result_valid;
  logic                             o_result_end;
  logic                             o_drop;

  modport master (
    output i_window, i_window_valid, i_window_end,
    output i_w_data, i_w_valid,
    input  o_w_loaded, o_result, o_result_valid,
    input  o_result_end, o_drop
  );

  modport slave (
    input  i_window, i_window_valid, i_window_end,
    input  i_w_data, i_w_valid,
    output o_w_loaded, o_result, o_result_valid,
    output o_result_end, o_drop
  );
endinterface

// File: rtl/conv2d_mac.sv
// conv2d_mac: K*K window MAC, 3-stage pipeline, double-banked coefficients.
// Optional ReLU on the output when CONV2D_MAC_RELU_EN is defined.
module conv2d_mac #(
  parameter int K_KERNEL = 3,
  parameter int BWD      = 8,
  parameter int WBWD     = 8
) (
  input  logic       clk,
  input  logic       clear,
  conv2d_mac_if.slave bus
);
  localparam int KK    = K_KERNEL * K_KERNEL;
  localparam int ACC_W = BWD + WBWD + $clog2(KK) + 1;
  localparam int PW    = BWD + WBWD;
  localparam int CW    = $clog2(KK + 1);

  typedef logic signed [WBWD-1:0]  coef_t;
  typedef logic signed [PW-1:0]    prod_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  coef_t         shd_q [KK];
  coef_t         act_q [KK];
  coef_t         bias_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          loaded_q, drop_q;
  logic          commit, acc;

  prod_t prod_d [KK];
  prod_t prod_q [KK];
  coef_t b1_q, b2_q;
  logic  v1_q, e1_q, v2_q, e2_q, v3_q, e3_q;
  acc_t  sum_d, sum_q, tot_d, res_d, res_q;

  assign commit = bus.i_w_valid && (cnt_q == CW'(KK));
  assign acc    = bus.i_window_valid && loaded_q;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.i_w_valid)
      cnt_d = commit ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    for (int i = 0; i < KK; i++)
      prod_d[i] = PW'($signed({1'b0, bus.i_window[i*BWD +: BWD]}))
                * PW'(act_q[i]);
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < KK; i++)
      sum_d = sum_d + ACC_W'(prod_q[i]);
  end

  assign tot_d = sum_q + ACC_W'(b2_q);

`ifdef CONV2D_MAC_RELU_EN
  assign res_d = tot_d[ACC_W-1] ? '0 : tot_d;
`else
  assign res_d = tot_d;
`endif

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      drop_q   <= 1'b0;
      bias_q   <= '0;
      for (int i = 0; i < KK; i++) begin
        shd_q[i] <= '0;
        act_q[i] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      drop_q <= drop_q | (bus.i_window_valid & ~loaded_q);
      for (int i = 0; i < KK; i++)
        if (bus.i_w_valid && cnt_q == CW'(i))
          shd_q[i] <= bus.i_w_data;
      // shadow is complete by the bias word, so the bank swaps whole
      if (commit) begin
        loaded_q <= 1'b1;
        bias_q   <= bus.i_w_data;
        for (int i = 0; i < KK; i++)
          act_q[i] <= shd_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      v1_q  <= 1'b0;
      e1_q  <= 1'b0;
      v2_q  <= 1'b0;
      e2_q  <= 1'b0;
      v3_q  <= 1'b0;
      e3_q  <= 1'b0;
      b1_q  <= '0;
      b2_q  <= '0;
      sum_q <= '0;
      res_q <= '0;
      for (int i = 0; i < KK; i++)
        prod_q[i] <= '0;
    end else begin
      v1_q <= acc;
      e1_q <= acc & bus.i_window_end;
      v2_q <= v1_q;
      e2_q <= e1_q;
      v3_q <= v2_q;
      e3_q <= e2_q;
      // bias rides with its window so a mid-stream reload stays coherent
      if (acc) begin
        b1_q <= bias_q;
        for (int i = 0; i < KK; i++)
          prod_q[i] <= prod_d[i];
      end
      if (v1_q) begin
        b2_q  <= b1_q;
        sum_q <= sum_d;
      end
      if (v2_q)
        res_q <= res_d;
    end
  end

  assign bus.o_w_loaded     = loaded_q;
  assign bus.o_drop         = drop_q;
  assign bus.o_result       = res_q;
  assign bus.o_result_valid = v3_q;
  assign bus.o_result_end   = e3_q;
endmodule

// File: tb/tb_conv2d_mac.sv
// tb_conv2d_mac: directed scoreboard bench for conv2d_mac.
// Expected results are queued at drive time and popped on o_result_valid.
module tb_conv2d_mac;
  localparam int K     = 3;
  localparam int KK    = K * K;
  localparam int BWD   = 8;
  localparam int WBWD  = 8;
  localparam int ACC_W = BWD + WBWD + $clog2(KK) + 1;

  typedef struct {
    longint res;
    bit     e;
    int     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic clear;
  int   cyc = 0;
  int   pass_n = 0;
  int   tot_n = 0;
  exp_t sb [$];
  exp_t got;

  int pix  [KK];
  int ld_c [KK];
  int ld_b;
  int mc   [KK];
  int mb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv2d_mac_if #(.K_KERNEL(K), .BWD(BWD), .WBWD(WBWD)) bus ();

  conv2d_mac #(.K_KERNEL(K), .BWD(BWD), .WBWD(WBWD)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    tot_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic longint rl(input longint v);
`ifdef CONV2D_MAC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic longint model();
    longint s;
    s = mb;
    for (int i = 0; i < KK; i++)
      s += longint'(pix[i]) * mc[i];
    return rl(s);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.i_window_valid = 1'b0;
    bus.i_window_end   = 1'b0;
  endtask

  task automatic set_win(input bit e, input bit keep, input longint ex);
    exp_t x;
    for (int i = 0; i < KK; i++)
      bus.i_window[i*BWD +: BWD] = BWD'(pix[i]);
    bus.i_window_valid = 1'b1;
    bus.i_window_end   = e;
    if (keep) begin
      x.res = ex;
      x.e   = e;
      x.cyc = cyc + 3;
      sb.push_back(x);
    end
  endtask

  task automatic load();
    for (int i = 0; i <= KK; i++) begin
      bus.i_w_valid = 1'b1;
      bus.i_w_data  = (i < KK) ? WBWD'(ld_c[i]) : WBWD'(ld_b);
      tick();
    end
    bus.i_w_valid = 1'b0;
    for (int i = 0; i < KK; i++)
      mc[i] = ld_c[i];
    mb = ld_b;
  endtask

  task automatic fill(input int p, input int c, input int b);
    for (int i = 0; i < KK; i++) begin
      pix[i]  = p;
      ld_c[i] = c;
    end
    ld_b = b;
  endtask

  always @(negedge clk) begin
    if (!clear && bus.o_result_end && !bus.o_result_valid)
      chk("end_without_valid", 1, 0);
    if (!clear && bus.o_result_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        got = sb.pop_front();
        chk("result", bus.o_result, got.res);
        chk("result_end", bus.o_result_end, got.e);
        chk("latency", cyc, got.cyc);
      end
    end
  end

  initial begin
    clear = 1'b1;
    bus.i_window       = '0;
    bus.i_window_valid = 1'b0;
    bus.i_window_end   = 1'b0;
    bus.i_w_data       = '0;
    bus.i_w_valid      = 1'b0;
    for (int i = 0; i < KK; i++)
      mc[i] = 0;
    mb = 0;
    #12;
    chk("rst_loaded", bus.o_w_loaded, 0);
    chk("rst_drop", bus.o_drop, 0);
    chk("rst_valid", bus.o_result_valid, 0);
    chk("rst_end", bus.o_result_end, 0);
    chk("rst_result", bus.o_result, 0);
    tick();
    clear = 1'b0;
    tick();

    // window before any load is dropped
    fill(10, 1, 0);
    set_win(1'b0, 1'b0, 0);
    tick();
    idle();
    repeat (5) tick();
    chk("drop_set", bus.o_drop, 1);
    chk("loaded_pre", bus.o_w_loaded, 0);
    load();
    chk("loaded_post", bus.o_w_loaded, 1);
    chk("drop_sticky", bus.o_drop, 1);

    set_win(1'b0, 1'b1, 90);
    tick();
    idle();
    repeat (6) tick();
    chk("hold_valid", bus.o_result_valid, 0);
    chk("hold_result", bus.o_result, 90);

    // reload to all 2 committing alongside window 9
    fill(1, 2, 0);
    for (int i = 0; i < 12; i++) begin
      set_win(i == 11, 1'b1, model());
      if (i < KK) begin
        bus.i_w_valid = 1'b1;
        bus.i_w_data  = WBWD'(ld_c[i]);
      end else if (i == KK) begin
        bus.i_w_valid = 1'b1;
        bus.i_w_data  = WBWD'(ld_b);
        for (int j = 0; j < KK; j++)
          mc[j] = ld_c[j];
        mb = ld_b;
      end else begin
        bus.i_w_valid = 1'b0;
      end
      tick();
    end
    idle();
    repeat (5) tick();

    fill(0, 0, 5);
    ld_c[4] = -1;
    for (int i = 0; i < KK; i++)
      pix[i] = $urandom_range(0, 255);
    pix[4] = 200;
    load();
`ifdef CONV2D_MAC_RELU_EN
    set_win(1'b1, 1'b1, 0);
`else
    set_win(1'b1, 1'b1, -195);
`endif
    tick();
    idle();
    repeat (5) tick();

    fill(255, -128, -128);
    load();
`ifdef CONV2D_MAC_RELU_EN
    set_win(1'b0, 1'b1, 0);
`else
    set_win(1'b0, 1'b1, -293888);
`endif
    tick();
    idle();
    repeat (5) tick();

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < KK; i++)
        ld_c[i] = $urandom_range(0, 255) - 128;
      ld_b = $urandom_range(0, 255) - 128;
      load();
      for (int w = 0; w < 3; w++) begin
        for (int i = 0; i < KK; i++)
          pix[i] = $urandom_range(0, 255);
        set_win(w == 2, 1'b1, model());
        tick();
      end
      idle();
      repeat (5) tick();
    end
    chk("sb_drained", sb.size(), 0);

    // clear with two windows in flight, the second tagged end
    fill(7, 1, 0);
    set_win(1'b0, 1'b0, 0);
    tick();
    set_win(1'b1, 1'b0, 0);
    tick();
    idle();
    @(posedge clk);
    #1;
    chk("flight_valid", bus.o_result_valid, 1);
    clear = 1'b1;
    #1;
    chk("clr_valid", bus.o_result_valid, 0);
    chk("clr_end", bus.o_result_end, 0);
    chk("clr_result", bus.o_result, 0);
    chk("clr_loaded", bus.o_w_loaded, 0);
    chk("clr_drop", bus.o_drop, 0);
    tick();
    clear = 1'b0;
    repeat (8) tick();
    chk("post_clr_loaded", bus.o_w_loaded, 0);
    chk("post_clr_valid", bus.o_result_valid, 0);
    chk("post_clr_sb", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/conv2d_mac.md
CONV2D_MAC -- requirements
Module: conv2d_mac

Interface
REQ-001 K_KERNEL, 3, window side length; window holds K_KERNEL*K_KERNEL pixels.
REQ-002 BWD, 8, pixel width, unsigned.
REQ-003 WBWD, 8, coefficient and bias width, signed two's complement.
REQ-004 ACC_W, BWD+WBWD+$clog2(K_KERNEL*K_KERNEL)+1, result width, signed.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 clear  in  1  reset, asynchronous, active-high.
REQ-007 i_window  in  K_KERNEL*K_KERNEL*BWD  pixel window, packed [row][col][bit].
REQ-008 i_window_valid  in  1  window qualifier, one window per asserted cycle; there is no backpressure.
REQ-009 i_window_end  in  1  last window of frame, meaningful only with i_window_valid.
REQ-010 i_w_data  in  WBWD  coefficient/bias load word.
REQ-011 i_w_valid  in  1  load word qualifier.
REQ-012 o_w_loaded  out  1  a complete coefficient set is active.
REQ-013 o_result  out  ACC_W  convolution result, signed.
REQ-014 o_result_valid  out  1  result qualifier.
REQ-015 o_result_end  out  1  result belongs to the last window of frame.
REQ-016 o_drop  out  1  sticky flag: a window arrived with no active coefficient set.

Function
REQ-017 Load stream order SHALL be: K_KERNEL*K_KERNEL coefficients in row-major order ([0][0] first), then one bias word, for K_KERNEL*K_KERNEL+1 words per set.
REQ-018 Load words SHALL fill a shadow bank under a word counter, 0..K_KERNEL*K_KERNEL; the counter SHALL wrap to 0 after the bias word.
REQ-019 On the cycle the bias word is accepted, shadow bank and bias SHALL be copied to the active bank at that clock edge, and o_w_loaded SHALL go 1 on the next cycle and stay 1 until reset.
REQ-020 A window accepted in the same cycle as the commit edge SHALL use the old active set; the next window SHALL use the new set.
REQ-021 Stage 1: nine (generally K*K) products pixel*coef SHALL be registered; pixels are zero-extended and coefficients sign-extended.
REQ-022 Stage 2: the sum of all products SHALL be registered at full ACC_W width, with no truncation.
REQ-023 Stage 3: sign-extended bias SHALL be added, optional ReLU applied (REQ-032), and the result registered to o_result.
REQ-024 Latency SHALL be exactly 3 cycles: a window valid at edge t SHALL produce o_result_valid at edge t+3. Throughput SHALL be one window per cycle.
REQ-025 i_window_end SHALL travel with its window; o_result_end SHALL assert only together with o_result_valid.
REQ-026 A window with o_w_loaded=0 SHALL be discarded: no result is produced, and o_drop is set until reset.
REQ-027 o_result SHALL hold its last value while o_result_valid=0.
REQ-028 Arithmetic SHALL never overflow at ACC_W, and no saturation logic is required.

Reset
REQ-029 When clear is asserted, all pipeline valid/end bits, o_result_valid, o_result_end, o_drop, o_w_loaded and the load counter SHALL go to 0 immediately, without waiting for a clock edge.
REQ-030 When clear is asserted, o_result, the active bank, the shadow bank and the bias SHALL go to 0.
REQ-031 Windows in flight when clear is asserted SHALL be lost. No output SHALL appear after clear is released until new coefficients are loaded and new windows arrive.

Configuration
REQ-032 Macro CONV2D_MAC_RELU_EN: when defined, a negative stage-3 sum SHALL be output as 0 and non-negative sums pass unchanged; when undefined, the signed sum SHALL be output unchanged. Latency is 3 cycles in both cases.

Verification
REQ-033 Load coefficients all 1 with bias 0; send a window with all pixels 10 at cycle t -> o_result=90, o_result_valid=1 at t+3 only.
REQ-034 Load a centre coefficient of -1 (others 0) with bias 5; send a window with centre pixel 200 -> o_result=-195, or 0 when CONV2D_MAC_RELU_EN is defined.
REQ-035 After reset, send a window before any load -> no o_result_valid and o_drop=1. Then complete a load -> o_w_loaded=1 and o_drop stays 1.
REQ-036 Stream windows back to back, each with all pixels 1; active set all 1/bias 0; a reload to all 2/bias 0 commits in the same cycle as window n -> results ...9, 9 (window n), 18 (window n+1)...
REQ-037 Use all pixels 255, all coefficients -128 and bias -128 -> o_result=-293888 exactly, with no wrap.
REQ-038 Assert clear asynchronously with 2 windows in flight, one carrying i_window_end -> all outputs 0 at once, no o_result_valid or o_result_end after release, and o_w_loaded=0.
